// File: rtl/ctrl_seq_pkg.sv
// Shared encodings for the control sequencer: stage codes,
// opcode class bit offsets (from the IR MSB) and ALU mode width.
package ctrl_seq_pkg;

  localparam logic [2:0] ST_LOAD    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_IRQ     = 3'd4;
  localparam logic [2:0] ST_HALT    = 3'd5;

  typedef enum logic [2:0] {
    S_LOAD    = ST_LOAD,
    S_FETCH   = ST_FETCH,
    S_DECODE  = ST_DECODE,
    S_EXECUTE = ST_EXECUTE,
    S_IRQ     = ST_IRQ,
    S_HALT    = ST_HALT
  } stage_e;

  // Class bit k lives at IR[IR_W-k]
  localparam int OFS_ALU  = 1;
  localparam int OFS_BR   = 2;
  localparam int OFS_MEM  = 3;
  localparam int OFS_JMP  = 4;
  localparam int OFS_MODE = 5;

  localparam int ALU_MODE_W = 4;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from (stage, IR, SR, dmem_rdy) to datapath
// enables. Interrupt strobes exist only with CTRL_SEQ_IRQ_EN.
module ctrl_decode
  import ctrl_seq_pkg::*;
#(
  parameter int IR_W = 12
) (
  input  logic                  i_rst,
  input  stage_e                i_stage,
  input  logic                  i_load_valid,
  input  logic [IR_W-1:0]       i_ir,
  input  logic [3:0]            i_sr,
  input  logic                  i_dmem_rdy,
  output logic                  o_pmem_le,
  output logic                  o_pmem_e,
  output logic                  o_ir_e,
  output logic                  o_dr_e,
  output logic                  o_dmem_e,
  output logic                  o_dmem_we,
  output logic                  o_pc_e,
  output logic                  o_acc_e,
  output logic                  o_sr_e,
  output logic                  o_alu_e,
  output logic                  o_mux1_sel,
  output logic                  o_mux2_sel,
  output logic [ALU_MODE_W-1:0] o_alu_mode,
  output logic                  o_halted,
`ifdef CTRL_SEQ_IRQ_EN
  output logic                  o_irq_ack,
  output logic                  o_irq_vec_sel,
`endif
  output logic                  o_mem_wait,
  output logic                  o_halt_op
);

  logic w_c_alu;
  logic w_c_br;
  logic w_c_mem;
  logic w_c_jmp;
  logic w_mem_cls;
  logic w_unused;

  assign w_c_alu   = i_ir[IR_W-OFS_ALU];
  assign w_c_br    = i_ir[IR_W-OFS_BR];
  assign w_c_mem   = i_ir[IR_W-OFS_MEM];
  assign w_c_jmp   = i_ir[IR_W-OFS_JMP];
  assign w_mem_cls = (i_ir[IR_W-1 -: 3] == 3'b001);
  assign w_unused  = &{1'b0, i_ir[IR_W-OFS_MODE-ALU_MODE_W:1]};

  always_comb begin
    o_pmem_le  = 1'b0;
    o_pmem_e   = 1'b0;
    o_ir_e     = 1'b0;
    o_dr_e     = 1'b0;
    o_dmem_e   = 1'b0;
    o_dmem_we  = 1'b0;
    o_pc_e     = 1'b0;
    o_acc_e    = 1'b0;
    o_sr_e     = 1'b0;
    o_alu_e    = 1'b0;
    o_mux1_sel = 1'b0;
    o_mux2_sel = 1'b0;
    o_alu_mode = '0;
    o_halted   = 1'b0;
`ifdef CTRL_SEQ_IRQ_EN
    o_irq_ack     = 1'b0;
    o_irq_vec_sel = 1'b0;
`endif
    o_mem_wait = 1'b0;
    o_halt_op  = 1'b0;
    if (!i_rst) begin
      unique case (i_stage)
        S_LOAD: begin
          o_pmem_le = i_load_valid;
          o_pmem_e  = i_load_valid;
        end
        S_FETCH: begin
          o_ir_e   = 1'b1;
          o_pmem_e = 1'b1;
        end
        S_DECODE: begin
          if (w_mem_cls) begin
            o_dmem_e   = 1'b1;
            o_dr_e     = i_dmem_rdy;
            o_mem_wait = ~i_dmem_rdy;
          end
        end
        S_EXECUTE: begin
          // Class bits are tested MSB first
          if (w_c_alu) begin
            o_pc_e     = 1'b1;
            o_acc_e    = 1'b1;
            o_sr_e     = 1'b1;
            o_alu_e    = 1'b1;
            o_mux1_sel = 1'b1;
            o_alu_mode = {1'b0, i_ir[IR_W-2 -: 3]};
          end else if (w_c_br) begin
            o_pc_e     = 1'b1;
            o_mux1_sel = i_sr[i_ir[IR_W-3 -: 2]];
          end else if (w_c_mem) begin
            o_sr_e     = 1'b1;
            o_alu_e    = 1'b1;
            o_mux1_sel = 1'b1;
            o_mux2_sel = 1'b1;
            o_dmem_e   = ~w_c_jmp;
            o_dmem_we  = ~w_c_jmp;
            o_alu_mode = i_ir[IR_W-OFS_MODE -: ALU_MODE_W];
          end else if (!w_c_jmp) begin
            o_pc_e     = 1'b1;
            o_mux1_sel = 1'b1;
          end else if (!i_ir[0]) begin
            o_pc_e = 1'b1;
          end else begin
            o_halt_op = 1'b1;
          end
        end
        S_IRQ: begin
`ifdef CTRL_SEQ_IRQ_EN
          o_pc_e        = 1'b1;
          o_irq_ack     = 1'b1;
          o_irq_vec_sel = 1'b1;
`endif
        end
        S_HALT: o_halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// LOAD/FETCH/DECODE/EXECUTE sequencer with program-load counter.
// Define CTRL_SEQ_IRQ_EN to add the irq port and IRQ entry stage.
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int IR_W       = 12,
  parameter int PMEM_DEPTH = 256,
  parameter int PA_W       = $clog2(PMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [IR_W-1:0]       IR,
  input  logic [3:0]            SR,
  input  logic                  dmem_rdy,
`ifdef CTRL_SEQ_IRQ_EN
  input  logic                  irq,
  output logic                  irq_ack,
  output logic                  irq_vec_sel,
`endif
  output logic [2:0]            stage,
  output logic [PA_W-1:0]       load_addr,
  output logic                  pmem_le,
  output logic                  pmem_e,
  output logic                  ir_e,
  output logic                  dr_e,
  output logic                  dmem_e,
  output logic                  dmem_we,
  output logic                  pc_e,
  output logic                  acc_e,
  output logic                  sr_e,
  output logic                  alu_e,
  output logic                  mux1_sel,
  output logic                  mux2_sel,
  output logic [ALU_MODE_W-1:0] alu_mode,
  output logic                  halted
);

  localparam logic [PA_W-1:0] LAST = PA_W'(PMEM_DEPTH-1);

  stage_e          r_state;
  stage_e          w_next;
  logic [PA_W-1:0] r_addr;
  logic            w_mem_wait;
  logic            w_halt_op;
  logic            w_irq_take;

`ifdef CTRL_SEQ_IRQ_EN
  logic r_rearm;

  assign w_irq_take = irq & r_rearm;

  // Re-arm needs irq low for a cycle after an entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rearm <= 1'b1;
    end else if (!irq) begin
      r_rearm <= 1'b1;
    end else if (r_state == S_IRQ) begin
      r_rearm <= 1'b0;
    end
  end
`else
  assign w_irq_take = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_LOAD && load_valid &&
          r_addr != LAST) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD: begin
        if (load_valid && r_addr == LAST) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        if (!w_mem_wait) begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (w_halt_op) begin
          w_next = S_HALT;
        end else if (w_irq_take) begin
          w_next = S_IRQ;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_IRQ: w_next = S_FETCH;
      S_HALT: begin
        if (w_irq_take) begin
          w_next = S_IRQ;
        end
      end
      default: w_next = S_LOAD;
    endcase
  end

  assign stage     = rst ? ST_LOAD : r_state;
  assign load_addr = rst ? '0 : r_addr;

  ctrl_decode #(
    .IR_W (IR_W)
  ) u_decode (
    .i_rst         (rst),
    .i_stage       (r_state),
    .i_load_valid  (load_valid),
    .i_ir          (IR),
    .i_sr          (SR),
    .i_dmem_rdy    (dmem_rdy),
    .o_pmem_le     (pmem_le),
    .o_pmem_e      (pmem_e),
    .o_ir_e        (ir_e),
    .o_dr_e        (dr_e),
    .o_dmem_e      (dmem_e),
    .o_dmem_we     (dmem_we),
    .o_pc_e        (pc_e),
    .o_acc_e       (acc_e),
    .o_sr_e        (sr_e),
    .o_alu_e       (alu_e),
    .o_mux1_sel    (mux1_sel),
    .o_mux2_sel    (mux2_sel),
    .o_alu_mode    (alu_mode),
    .o_halted      (halted),
`ifdef CTRL_SEQ_IRQ_EN
    .o_irq_ack     (irq_ack),
    .o_irq_vec_sel (irq_vec_sel),
`endif
    .o_mem_wait    (w_mem_wait),
    .o_halt_op     (w_halt_op)
  );

endmodule
